// File: rtl/cbus_mem_responder.sv
// CBus memory-side responder: word-addressed 64-bit RAM serving single and
// FIXED/INCR bursts after a programmable initial latency.
module cbus_mem_responder #(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        creq_valid,
  input  logic        creq_is_write,
  input  logic [2:0]  creq_size,
  input  logic [63:0] creq_addr,
  input  logic [7:0]  creq_strobe,
  input  logic [63:0] creq_data,
  input  logic [3:0]  creq_len,
  input  logic [1:0]  creq_burst,
  output logic        cresp_ready,
  output logic        cresp_last,
  output logic [63:0] cresp_data
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_e;

  state_e          state_q, state_d;
  logic            is_write_q, is_write_d;
  logic            fixed_q, fixed_d;
  logic [3:0]      len_q, len_d;
  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic [3:0]      beat_cnt_q, beat_cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            mem_we;

  logic [63:0] mem [DEPTH];

  // Size is informational only and sub-word address bits never index the array.
  logic unused_bits;
  assign unused_bits = ^{creq_size, creq_addr[63:3+AW], creq_addr[2:0]};

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    fixed_d    = fixed_q;
    len_d      = len_q;
    wait_cnt_d = wait_cnt_q;
    beat_cnt_d = beat_cnt_q;
    idx_d      = idx_q;
    mem_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (creq_valid) begin
          is_write_d = creq_is_write;
          fixed_d    = (creq_burst == 2'b00);
          len_d      = creq_len;
          idx_d      = creq_addr[3 +: AW];
          wait_cnt_d = 4'(LATENCY);
          beat_cnt_d = 4'd0;
          state_d    = (LATENCY == 0) ? S_BURST : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!creq_valid) begin
          state_d = S_IDLE;
        end else if (wait_cnt_q <= 4'd1) begin
          state_d = S_BURST;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      S_BURST: begin
        // A dropped valid is a protocol violation: abandon without writing.
        if (!creq_valid) begin
          state_d = S_IDLE;
        end else begin
          mem_we     = is_write_q;
          beat_cnt_d = beat_cnt_q + 4'd1;
          if (!fixed_q) idx_d = idx_q + AW'(1);
          if (beat_cnt_q == len_q) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      is_write_q <= 1'b0;
      fixed_q    <= 1'b0;
      len_q      <= 4'd0;
      wait_cnt_q <= 4'd0;
      beat_cnt_q <= 4'd0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      fixed_q    <= fixed_d;
      len_q      <= len_d;
      wait_cnt_q <= wait_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      idx_q      <= idx_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 8; k++) begin
        if (creq_strobe[k]) mem[idx_q][8*k +: 8] <= creq_data[8*k +: 8];
      end
    end
  end

  assign cresp_ready = (state_q == S_BURST);
  assign cresp_last  = cresp_ready && (beat_cnt_q == len_q);
  assign cresp_data  = (cresp_ready && !is_write_q) ? mem[idx_q] : 64'd0;

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Directed bench for cbus_mem_responder: two instances (LATENCY 2 and 0)
// with read data checked against a scoreboard queue.
module tb_cbus_mem_responder;
  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld  [2];
  logic        wr   [2];
  logic [2:0]  sz   [2];
  logic [63:0] addr [2];
  logic [7:0]  strb [2];
  logic [63:0] wd   [2];
  logic [3:0]  len  [2];
  logic [1:0]  bst  [2];
  logic        rdy  [2];
  logic        lst  [2];
  logic [63:0] dat  [2];

  logic [63:0] sbq [$];
  logic [63:0] wq  [$];
  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cbus_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(rst_n), .creq_valid(vld[0]), .creq_is_write(wr[0]),
    .creq_size(sz[0]), .creq_addr(addr[0]), .creq_strobe(strb[0]), .creq_data(wd[0]),
    .creq_len(len[0]), .creq_burst(bst[0]), .cresp_ready(rdy[0]), .cresp_last(lst[0]),
    .cresp_data(dat[0]));

  cbus_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .reset(rst_n), .creq_valid(vld[1]), .creq_is_write(wr[1]),
    .creq_size(sz[1]), .creq_addr(addr[1]), .creq_strobe(strb[1]), .creq_data(wd[1]),
    .creq_len(len[1]), .creq_burst(bst[1]), .cresp_ready(rdy[1]), .cresp_last(lst[1]),
    .cresp_data(dat[1]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // One transaction on instance sel. Write data comes from wq, read expectations
  // from sbq. stop < len+1 drops valid after that many beats.
  task automatic txn(input int sel, input bit w, input logic [63:0] a, input int n,
                     input logic [1:0] b, input logic [7:0] s, input int stop,
                     input int exp_lat);
    int cnt;
    logic [63:0] e;
    @(negedge clk);
    wr[sel] = w; addr[sel] = a; len[sel] = 4'(n); bst[sel] = b; strb[sel] = s;
    sz[sel] = 3'd3;
    wd[sel] = (w && wq.size() > 0) ? wq.pop_front() : 64'd0;
    vld[sel] = 1'b1;
    cnt = 0;
    while (!rdy[sel] && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("latency", 64'(cnt), 64'(exp_lat));
    for (int i = 0; i <= n && i < stop; i++) begin
      if (i > 0) @(negedge clk);
      chk("ready", 64'(rdy[sel]), 64'd1);
      chk("last", 64'(lst[sel]), 64'(i == n));
      if (!w) begin
        e = (sbq.size() > 0) ? sbq.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;
        chk("rdata", dat[sel], e);
      end else begin
        chk("wdata_zero", dat[sel], 64'd0);
      end
      @(posedge clk);
      #1;
      if (w && wq.size() > 0) wd[sel] = wq.pop_front();
    end
    vld[sel] = 1'b0;
    if (stop <= n) @(negedge clk);
    @(negedge clk);
    chk("ready_after", 64'(rdy[sel]), 64'd0);
    wq.delete();
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; wr[i] = 1'b0; sz[i] = 3'd3; addr[i] = 64'd0;
      strb[i] = 8'h00; wd[i] = 64'd0; len[i] = 4'd0; bst[i] = 2'd1;
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(rdy[0]), 64'd0);
    chk("rst_last", 64'(lst[0]), 64'd0);
    chk("rst_data", dat[0], 64'd0);
    chk("rst_ready_l0", 64'(rdy[1]), 64'd0);
    rst_n = 1'b1;

    // Reset asserted mid-way through a 16-beat read.
    @(negedge clk);
    wr[0] = 1'b0; addr[0] = 64'h0; len[0] = 4'd15; bst[0] = 2'd1; vld[0] = 1'b1;
    cnt = 0;
    while (!rdy[0] && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("mid_lat", 64'(cnt), 64'd3);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_ready", 64'(rdy[0]), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(rdy[0]), 64'd0);
    chk("mid_rst_last", 64'(lst[0]), 64'd0);
    chk("mid_rst_data", dat[0], 64'd0);
    vld[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Full-strobe single write then read back.
    wq.push_back(64'hDEADBEEF_CAFEF00D);
    txn(0, 1'b1, 64'h100, 0, 2'd1, 8'hFF, 99, 3);
    sbq.push_back(64'hDEADBEEF_CAFEF00D);
    txn(0, 1'b0, 64'h100, 0, 2'd1, 8'h00, 99, 3);

    // Partial strobe merge; low address bits ignored on the read.
    wq.push_back(64'hFFFFFFFF_FFFFFFFF);
    txn(0, 1'b1, 64'h200, 0, 2'd1, 8'hFF, 99, 3);
    wq.push_back(64'h11111111_22222222);
    txn(0, 1'b1, 64'h200, 0, 2'd1, 8'h0F, 99, 3);
    sbq.push_back(64'hFFFFFFFF_22222222);
    txn(0, 1'b0, 64'h205, 0, 2'd1, 8'h00, 99, 3);

    // INCR wrap at the end of the array; read uses a reserved burst code.
    for (int i = 1; i <= 4; i++) wq.push_back(64'(i));
    txn(0, 1'b1, 64'((DEPTH - 2) * 8), 3, 2'd1, 8'hFF, 99, 3);
    for (int i = 1; i <= 4; i++) sbq.push_back(64'(i));
    txn(0, 1'b0, 64'((DEPTH - 2) * 8), 3, 2'd3, 8'h00, 99, 3);
    sbq.push_back(64'd3);
    txn(0, 1'b0, 64'(DEPTH * 8), 0, 2'd1, 8'h00, 99, 3);

    // FIXED burst on the zero-latency instance.
    wq.push_back(64'h0);
    wq.push_back(64'h5555);
    txn(1, 1'b1, 64'h40, 1, 2'd1, 8'hFF, 99, 1);
    wq.push_back(64'hA); wq.push_back(64'hB); wq.push_back(64'hC); wq.push_back(64'hD);
    txn(1, 1'b1, 64'h40, 3, 2'd0, 8'hFF, 99, 1);
    sbq.push_back(64'hD);
    sbq.push_back(64'h5555);
    txn(1, 1'b0, 64'h40, 1, 2'd1, 8'h00, 99, 1);

    // Valid dropped after two beats of an 8-beat write.
    for (int i = 0; i < 8; i++) wq.push_back(64'hFFFF_0000 + 64'(i));
    txn(0, 1'b1, 64'h1000, 7, 2'd1, 8'hFF, 99, 3);
    for (int i = 0; i < 8; i++) wq.push_back(64'h61 + 64'(i));
    txn(0, 1'b1, 64'h1000, 7, 2'd1, 8'hFF, 2, 3);
    sbq.push_back(64'h61);
    sbq.push_back(64'h62);
    for (int i = 2; i < 8; i++) sbq.push_back(64'hFFFF_0000 + 64'(i));
    txn(0, 1'b0, 64'h1000, 7, 2'd1, 8'h00, 99, 3);

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
